// File: rtl/reg_file_decoded.sv
// -----------------------------------------------------------------------------
// reg_file_decoded
//   Register file with an integrated, enable-gated one-hot write decoder,
//   two combinational read ports, optional write-to-read bypass and a PC
//   register that auto-increments on pc_inc.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears storage and we_onehot)
//   we         write enable
//   wr_addr    write register select
//   wr_data    write data
//   pc_inc     advance the PC register by PC_STEP on this edge
//   ra_addr    read port A select
//   rb_addr    read port B select
//   ra_data    read port A data (combinational)
//   rb_data    read port B data (combinational)
//   pc_out     current PC register value (registered)
//   we_onehot  decoded write enables captured on the last edge
// -----------------------------------------------------------------------------
module reg_file_decoded #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int BYPASS   = 1,
    parameter int PC_INDEX = 15,
    parameter int PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pc_inc,
    input  logic [ADDR_W-1:0]        ra_addr,
    input  logic [ADDR_W-1:0]        rb_addr,
    output logic [DATA_W-1:0]        ra_data,
    output logic [DATA_W-1:0]        rb_data,
    output logic [DATA_W-1:0]        pc_out,
    output logic [(1<<ADDR_W)-1:0]   we_onehot
);

    localparam int              NREGS     = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] PC_STEP_V = DATA_W'(PC_STEP);
    localparam logic            BYP_EN    = (BYPASS != 0) ? 1'b1 : 1'b0;

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  dec_s;
    logic [NREGS-1:0]  we_onehot_r;

    // One-hot write decoder: no bit is hot unless we is asserted.
    always_comb begin
        dec_s = {NREGS{1'b0}};
        if (we) begin
            dec_s[wr_addr] = 1'b1;
        end else begin
            dec_s = {NREGS{1'b0}};
        end
    end

    // Storage: an explicit write wins over the PC auto-increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (dec_s[i]) begin
                    regs_r[i] <= wr_data;
                end else if ((i == PC_INDEX) && pc_inc) begin
                    // Modulo-2^DATA_W wrap is intentional and silent.
                    regs_r[i] <= regs_r[i] + PC_STEP_V;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Capture of the decode so the control side can see which register moved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_onehot_r <= {NREGS{1'b0}};
        end else begin
            we_onehot_r <= dec_s;
        end
    end

    // Read port A, forwarding the in-flight write when bypass is enabled.
    always_comb begin
        ra_data = regs_r[ra_addr];
        if (BYP_EN && we && (ra_addr == wr_addr)) begin
            ra_data = wr_data;
        end else begin
            ra_data = regs_r[ra_addr];
        end
    end

    // Read port B, same forwarding rule as port A.
    always_comb begin
        rb_data = regs_r[rb_addr];
        if (BYP_EN && we && (rb_addr == wr_addr)) begin
            rb_data = wr_data;
        end else begin
            rb_data = regs_r[rb_addr];
        end
    end

    assign pc_out    = regs_r[PC_INDEX];
    assign we_onehot = we_onehot_r;

endmodule

// File: tb/tb_reg_file_decoded.sv
module tb_reg_file_decoded;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pc_inc;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;

    logic [31:0] ra0, rb0, pc0;
    logic [15:0] oh0;
    logic [31:0] ra1, rb1, pc1;
    logic [15:0] oh1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain array of register contents plus last decode.
    logic [31:0] mregs [16];
    logic [15:0] moh;

    reg_file_decoded #(.BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_inc(pc_inc), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra0), .rb_data(rb0), .pc_out(pc0), .we_onehot(oh0)
    );

    reg_file_decoded #(.BYPASS(0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_inc(pc_inc), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra1), .rb_data(rb1), .pc_out(pc1), .we_onehot(oh1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit byp, input logic [3:0] a);
        if (byp && we && a == wr_addr) return wr_data;
        return mregs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
        moh = 16'h0;
    endtask

    // Model of one rising edge, expressed directly from the register-file rules.
    task automatic model_edge();
        logic [31:0] next_pc;
        if (!rst_n) return;
        next_pc = mregs[15] + (pc_inc ? 32'd4 : 32'd0);
        if (we) begin
            mregs[wr_addr] = wr_data;
            moh = 16'h1 << wr_addr;
        end else begin
            moh = 16'h0;
        end
        if (!(we && wr_addr == 4'd15)) mregs[15] = next_pc;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ra_byp"},  ra0, exp_rd(1'b1, ra_addr));
        chk({tag, ".rb_byp"},  rb0, exp_rd(1'b1, rb_addr));
        chk({tag, ".ra_nob"},  ra1, exp_rd(1'b0, ra_addr));
        chk({tag, ".rb_nob"},  rb1, exp_rd(1'b0, rb_addr));
        chk({tag, ".pc"},      pc0, mregs[15]);
        chk({tag, ".pc_nob"},  pc1, mregs[15]);
        chk({tag, ".oh"},      {16'h0, oh0}, {16'h0, moh});
        chk({tag, ".oh_nob"},  {16'h0, oh1}, {16'h0, moh});
    endtask

    // Called at a falling edge with inputs already driven: check, clock, return at next falling edge.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                         input logic pi, input logic [3:0] a, input logic [3:0] b);
        we = w; wr_addr = wa; wr_data = wd; pc_inc = pi; ra_addr = a; rb_addr = b;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0);
        model_clear();

        // 1. reset state, all registers through both ports
        #2;
        for (int i = 0; i < 16; i++) begin
            ra_addr = i[3:0]; rb_addr = 4'(15 - i);
            #1;
            check_all("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 2. single write and idle
        drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd3, 4'd0);
        tick("wr_r3");
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 4'd3);
        #1;
        chk("r3_readback", ra1, 32'hDEADBEEF);
        chk("oh_r3", {16'h0, oh0}, 32'h0000_0008);
        tick("after_r3");
        #1;
        chk("oh_idle", {16'h0, oh0}, 32'h0);
        tick("idle");

        // 3. sweep writes, onehot walks
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i[3:0], 32'h11111111 * i, 1'b0, i[3:0], 4'(i + 1));
            tick("sweep");
            #1;
            chk("oh_walk", {16'h0, oh0}, 32'h1 << i);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 32'h0, 1'b0, i[3:0], i[3:0]);
            #1;
            chk("sweep_rd", rb1, 32'h11111111 * i);
            tick("sweep_rd");
        end

        // 4. bypass vs no bypass on R5
        drive(1'b1, 4'd5, 32'h12345678, 1'b0, 4'd5, 4'd5);
        #1;
        chk("byp_on", ra0, 32'h12345678);
        chk("byp_off", ra1, 32'h55555555);
        tick("bypass");

        // 5. PC increments, write priority and wrap
        drive(1'b1, 4'd15, 32'h0, 1'b0, 4'd15, 4'd0);
        tick("pc_clear");
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd15);
            tick("pc_inc");
            #1;
            chk("pc_step", pc0, 32'd4 * i);
        end
        drive(1'b1, 4'd15, 32'h100, 1'b1, 4'd15, 4'd1);
        #1;
        chk("pc_byp_wr", ra0, 32'h100);
        tick("pc_wr_pri");
        #1;
        chk("pc_wr_pri", pc0, 32'h100);
        drive(1'b1, 4'd15, 32'hFFFFFFFC, 1'b0, 4'd0, 4'd1);
        tick("pc_wr_top");
        drive(1'b1, 4'd2, 32'hCAFEF00D, 1'b1, 4'd15, 4'd2);
        #1;
        chk("pc_no_byp_inc", ra0, 32'hFFFFFFFC);
        tick("pc_wrap");
        #1;
        chk("pc_wrap", pc0, 32'h0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 7) == 0) ra_addr = wr_addr;
            if ($urandom_range(0, 7) == 0) wr_addr = 4'd15;
            tick("rand");
        end

        // 6. asynchronous reset mid-cycle, write under reset ignored
        drive(1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, 4'd7, 4'd15);
        tick("wr_r7");
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd7, 4'd15);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_r7", ra0, 32'h0);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_oh", {16'h0, oh0}, 32'h0);
        check_all("rst_async");
        @(negedge clk);
        drive(1'b1, 4'd7, 32'h87654321, 1'b1, 4'd7, 4'd7);
        tick("wr_in_rst");
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd7, 4'd15);
        #1;
        chk("rst_wr_ignored", ra0, 32'h0);
        chk("rst_pc_held", pc0, 32'h0);
        rst_n = 1'b1;
        tick("post_rst");
        tick("post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
